// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes and FSM states.
// Imported by alu_seq and its iterative multiplier.
package alu_pkg;

    localparam logic [3:0] OP_EQ  = 4'h0;
    localparam logic [3:0] OP_SLT = 4'h1;
    localparam logic [3:0] OP_XOR = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_SUB = 4'h6;
    localparam logic [3:0] OP_ADD = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_SHR = 4'h9;
    localparam logic [3:0] OP_SAR = 4'hA;
    localparam logic [3:0] OP_MUL = 4'hB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier: one partial product per cycle, WIDTH steps per op.
// done flags the cycle whose edge performs the final step; product is that step's sum.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    always_comb begin
        product = acc + (mplier[0] ? mcand : '0);
        done    = (cnt == CW'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            acc    <= '0;
            mplier <= b;
            cnt    <= CW'(WIDTH);
        end else if (cnt != '0) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-generic ALU with valid/ready on both sides.
// Single-cycle ops complete on the accept edge; MUL iterates WIDTH cycles.
import alu_pkg::*;

module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_t state;

    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic               mul_hi;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH-1:0] alu_r;
    logic             alu_c;
    logic             alu_v;
    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;
    logic [WIDTH:0]   sar_ext;

    assign in_ready  = !rst && (state == IDLE || (state == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op == OP_MUL);
    assign mul_hi    = |mul_product[2*WIDTH-1:WIDTH];

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Shifts carry one guard bit so the last bit shifted out lands in bit 0 / bit WIDTH.
    always_comb begin
        sh      = b[SHW-1:0];
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        shl_ext = {1'b0, a} << sh;
        shr_ext = {a, 1'b0} >> sh;
        sar_ext = $signed({a, 1'b0}) >>> sh;
        alu_r   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (op)
            OP_EQ:  alu_r = {{(WIDTH-1){1'b0}}, a == b};
            OP_SLT: alu_r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_XOR: alu_r = a ^ b;
            OP_OR:  alu_r = a | b;
            OP_AND: alu_r = a & b;
            OP_NOT: alu_r = ~a;
            OP_SUB: begin
                alu_r = diff[WIDTH-1:0];
                alu_c = diff[WIDTH];
                alu_v = (a[WIDTH-1] != b[WIDTH-1]) &&
                        (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADD: begin
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (a[WIDTH-1] == b[WIDTH-1]) &&
                        (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SHL: begin
                alu_r = shl_ext[WIDTH-1:0];
                alu_c = shl_ext[WIDTH];
            end
            OP_SHR: begin
                alu_r = shr_ext[WIDTH:1];
                alu_c = shr_ext[0];
            end
            OP_SAR: begin
                alu_r = sar_ext[WIDTH:1];
                alu_c = sar_ext[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b1;
            busy      <= 1'b0;
        end else if (accept) begin
            if (op == OP_MUL) begin
                state     <= CALC;
                busy      <= 1'b1;
                out_valid <= 1'b0;
            end else begin
                state     <= DONE;
                out_valid <= 1'b1;
                result    <= alu_r;
                carry     <= alu_c;
                overflow  <= alu_v;
                zero      <= (alu_r == '0);
            end
        end else begin
            unique case (state)
                CALC: if (mul_done) begin
                    state     <= DONE;
                    busy      <= 1'b0;
                    out_valid <= 1'b1;
                    result    <= mul_product[WIDTH-1:0];
                    carry     <= mul_hi;
                    overflow  <= mul_hi;
                    zero      <= (mul_product[WIDTH-1:0] == '0);
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed vectors, random ops
// against an arithmetic reference model, backpressure, streaming and reset.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;
    logic         zero;
    logic         busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .busy      (busy)
    );

    function automatic bit in_range(input int s);
        return (s >= -(1 << (W-1))) && (s < (1 << (W-1)));
    endfunction

    // {result, carry, overflow, zero} computed from the opcode definitions.
    function automatic logic [W+2:0] model(input logic [3:0] o,
                                           input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        int ux, uy, sx, sy, n, t;
        logic [W-1:0] r;
        logic c, v;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        n  = uy % W;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        t = 0;
        case (o)
            4'h0: r = {{(W-1){1'b0}}, x == y};
            4'h1: r = {{(W-1){1'b0}}, sx < sy};
            4'h2: r = x ^ y;
            4'h3: r = x | y;
            4'h4: r = x & y;
            4'h5: r = ~x;
            4'h6: begin
                t = ux - uy;
                r = t[W-1:0];
                c = (ux >= uy);
                v = !in_range(sx - sy);
            end
            4'h7: begin
                t = ux + uy;
                r = t[W-1:0];
                c = (t >= (1 << W));
                v = !in_range(sx + sy);
            end
            4'h8: begin
                t = ux << n;
                r = t[W-1:0];
                c = (n != 0) && t[W];
            end
            4'h9: begin
                t = ux >> n;
                r = t[W-1:0];
                c = (n != 0) && (((ux >> (n - 1)) & 1) != 0);
            end
            4'hA: begin
                t = sx >>> n;
                r = t[W-1:0];
                c = (n != 0) && (((ux >> (n - 1)) & 1) != 0);
            end
            4'hB: begin
                t = ux * uy;
                r = t[W-1:0];
                c = (t >= (1 << W));
                v = c;
            end
            default: ;
        endcase
        return {r, c, v, (r == '0)};
    endfunction

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W+2:0] exp_v,
                          input string name);
        int lat, busy_n, exp_lat, exp_busy;
        lat = -1;
        busy_n = 0;
        exp_lat = (o == 4'hB) ? W : 0;
        exp_busy = (o == 4'hB) ? W : 0;
        @(negedge clk);
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s in_ready: got %b expected 1", name, in_ready);
        end
        @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            a = W'($urandom);
            b = W'($urandom);
            op = 4'($urandom);
            if (out_valid === 1'b1) begin
                lat = i;
                break;
            end
            if (busy === 1'b1) busy_n++;
        end
        tests++;
        if (lat != exp_lat) begin
            fails++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        tests++;
        if (busy_n != exp_busy) begin
            fails++;
            $display("FAIL %s busy cycles: got %0d expected %0d", name, busy_n, exp_busy);
        end
        tests++;
        if ({result, carry, overflow, zero} !== exp_v) begin
            fails++;
            $display("FAIL %s r/c/v/z: got %h %b%b%b expected %h %b%b%b", name,
                     result, carry, overflow, zero,
                     exp_v[W+2:3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset in_ready_in_rst: got %b expected 0", in_ready);
        end
        rst = 1'b0;
        #1;
        tests++;
        if ({out_valid, result, carry, overflow, zero, busy, in_ready} !==
            {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset state: got v=%b r=%h c=%b o=%b z=%b busy=%b rdy=%b expected v=0 r=00 c=0 o=0 z=1 busy=0 rdy=1",
                     out_valid, result, carry, overflow, zero, busy, in_ready);
        end
    endtask

    task automatic test_directed();
        run_op(4'h7, 8'h7F, 8'h01, {8'h80, 3'b010}, "add_7f_01");
        run_op(4'h6, 8'h00, 8'h01, {8'hFF, 3'b000}, "sub_00_01");
        run_op(4'h6, 8'h80, 8'h01, {8'h7F, 3'b110}, "sub_80_01");
        run_op(4'h0, 8'h5A, 8'h5A, {8'h01, 3'b000}, "eq_5a");
        run_op(4'h1, 8'h80, 8'h01, {8'h01, 3'b000}, "slt_80_01");
        run_op(4'h1, 8'h01, 8'h80, {8'h00, 3'b001}, "slt_01_80");
        run_op(4'hA, 8'h80, 8'h03, {8'hF0, 3'b000}, "sar_80_3");
        run_op(4'h9, 8'h81, 8'h01, {8'h40, 3'b100}, "shr_81_1");
        run_op(4'h8, 8'hC0, 8'h00, {8'hC0, 3'b000}, "shl_c0_0");
        run_op(4'h8, 8'hC0, 8'h0A, {8'h00, 3'b101}, "shl_c0_amt_b_low");
        run_op(4'h5, 8'h0F, 8'h00, {8'hF0, 3'b000}, "not_0f");
        run_op(4'hB, 8'h10, 8'h10, {8'h00, 3'b111}, "mul_10_10");
        run_op(4'hB, 8'h0F, 8'h0F, {8'hE1, 3'b000}, "mul_0f_0f");
        run_op(4'hD, 8'h12, 8'h34, {8'h00, 3'b001}, "reserved_d");
    endtask

    task automatic test_random();
        logic [3:0] o;
        logic [W-1:0] x, y;
        for (int i = 0; i < 60; i++) begin
            o = 4'($urandom_range(0, 15));
            x = W'($urandom);
            y = W'($urandom);
            if (i % 7 == 0) x = 8'h7F;
            if (i % 11 == 0) y = 8'h80;
            run_op(o, x, y, model(o, x, y), "random");
        end
    endtask

    task automatic test_backpressure();
        logic [W+2:0] e1, e2;
        e1 = model(4'h7, 8'h33, 8'hE0);
        e2 = model(4'h2, 8'hA5, 8'h3C);
        @(negedge clk);
        op = 4'h7;
        a = 8'h33;
        b = 8'hE0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++;
            if ({out_valid, in_ready, result, carry, overflow, zero} !==
                {1'b1, 1'b0, e1}) begin
                fails++;
                $display("FAIL backpressure hold: got v=%b rdy=%b %h%b%b%b expected v=1 rdy=0 %h",
                         out_valid, in_ready, result, carry, overflow, zero, e1);
            end
            op = 4'h2;
            a = 8'hA5;
            b = 8'h3C;
            in_valid = 1'b1;
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL backpressure release in_ready: got %b expected 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if ({out_valid, result, carry, overflow, zero} !== {1'b1, e2}) begin
            fails++;
            $display("FAIL backpressure next: got v=%b %h%b%b%b expected v=1 %h",
                     out_valid, result, carry, overflow, zero, e2);
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 20;
        logic [3:0] ops[N];
        logic [W-1:0] xs[N], ys[N];
        for (int i = 0; i < N; i++) begin
            ops[i] = 4'($urandom_range(0, 14));
            if (ops[i] == 4'hB) ops[i] = 4'hF;
            xs[i] = W'($urandom);
            ys[i] = W'($urandom);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        op = ops[0];
        a = xs[0];
        b = ys[0];
        for (int i = 0; i < N; i++) begin
            tests++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL b2b in_ready[%0d]: got %b expected 1", i, in_ready);
            end
            @(posedge clk);
            @(negedge clk);
            tests++;
            if ({out_valid, result, carry, overflow, zero} !==
                {1'b1, model(ops[i], xs[i], ys[i])}) begin
                fails++;
                $display("FAIL b2b result[%0d]: got v=%b %h%b%b%b expected v=1 %h",
                         i, out_valid, result, carry, overflow, zero,
                         model(ops[i], xs[i], ys[i]));
            end
            if (i < N - 1) begin
                op = ops[i+1];
                a = xs[i+1];
                b = ys[i+1];
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        @(negedge clk);
        op = 4'hB;
        a = 8'h37;
        b = 8'h5A;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if ({out_valid, busy, result, carry, overflow, zero, in_ready} !==
            {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL mid_mul_reset state: got v=%b busy=%b r=%h c=%b o=%b z=%b rdy=%b expected v=0 busy=0 r=00 c=0 o=0 z=1 rdy=1",
                     out_valid, busy, result, carry, overflow, zero, in_ready);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL mid_mul_reset stale[%0d]: got v=%b busy=%b expected 0 0",
                         k, out_valid, busy);
            end
        end
        run_op(4'h7, 8'h01, 8'h01, {8'h02, 3'b000}, "add_after_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
